// File: rtl/tree_add_sched.sv
// tree_add_sched: walks n/T chunks per row through tree_add, accumulates, emits row sums mod 2^D
module tree_add_sched #(
    parameter int T      = 16,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16,
    parameter int ROW_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [2:0]        i_sec_lev,
    input  logic              i_mode,
    input  logic [ROW_W-1:0]  i_rows,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_valid,
    output logic              o_tree_mode,
    output logic [2:0]        o_tree_sec_lev,
    output logic [WIDTH-1:0]  o_tree_element,
    input  logic [WIDTH-1:0]  i_tree_result,
    output logic [WIDTH-1:0]  o_result,
    output logic              o_result_valid,
    input  logic              i_result_ready
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

    localparam logic [ADDR_W-1:0] C1 = ADDR_W'(640 / T);
    localparam logic [ADDR_W-1:0] C3 = ADDR_W'(976 / T);
    localparam logic [ADDR_W-1:0] C5 = ADDR_W'(1344 / T);

    state_t             state, state_n;
    logic [2:0]         sec_lev_q;
    logic               mode_q, err_q, sec_ok, last_chunk, last_row;
    logic [ROW_W-1:0]   rows_q, row;
    logic [ADDR_W-1:0]  chunk, n_chunks;
    logic [WIDTH-1:0]   acc, mask;

    assign sec_ok     = i_sec_lev == 3'd1 || i_sec_lev == 3'd3 || i_sec_lev == 3'd5;
    assign n_chunks   = sec_lev_q == 3'd1 ? C1 : sec_lev_q == 3'd3 ? C3 : C5;
    assign mask       = sec_lev_q == 3'd1 ? WIDTH'(32'h7FFF) : WIDTH'(32'hFFFF);
    assign last_chunk = chunk == n_chunks - ADDR_W'(1);
    assign last_row   = row == rows_q - ROW_W'(1);

    assign o_busy         = state != IDLE;
    assign o_done         = state == DONE;
    assign o_err          = err_q;
    assign o_rd_en        = state == FETCH;
    assign o_rd_addr      = ADDR_W'(row) * n_chunks + chunk;
    assign o_tree_mode    = mode_q;
    assign o_tree_sec_lev = sec_lev_q;
    assign o_tree_element = acc;
    assign o_result       = acc & mask;
    assign o_result_valid = state == EMIT;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (i_start && sec_ok) state_n = i_rows == '0 ? DONE : FETCH;
            FETCH:   state_n = WAIT;
            WAIT:    if (i_rd_valid) state_n = last_chunk ? EMIT : FETCH;
            EMIT:    if (i_result_ready) state_n = last_row ? DONE : FETCH;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sec_lev_q <= '0;
            mode_q    <= 1'b0;
            rows_q    <= '0;
            row       <= '0;
            chunk     <= '0;
            acc       <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= state == IDLE && i_start && !sec_ok;
            if (state == IDLE && i_start && sec_ok) begin
                sec_lev_q <= i_sec_lev;
                mode_q    <= i_mode;
                rows_q    <= i_rows;
                row       <= '0;
                chunk     <= '0;
                acc       <= '0;
            end
            if (state == WAIT && i_rd_valid) begin
                acc <= i_tree_result;
                if (!last_chunk) chunk <= chunk + ADDR_W'(1);
            end
            if (state == EMIT && i_result_ready) begin
                acc   <= '0;
                chunk <= '0;
                row   <= row + ROW_W'(1);
            end
        end
    end
endmodule
